// File: rtl/dsi_packet_assembler_pkg.sv
// Shared types and constants for the DSI packet assembler.
// Also holds the byte-wise reflected CRC-16 step used by crc_calculator.
package dsi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        CRC     = 2'd3
    } state_t;

    localparam logic [15:0] CRC_INIT   = 16'hFFFF;
    localparam logic [15:0] CSUM_NONE  = 16'h0000;  // DSI "checksum not calculated"
    localparam logic [1:0]  HDR_BYTES  = 2'd3;      // out_bytes code: 4 bytes
    localparam logic [1:0]  CSUM_BYTES = 2'd1;      // out_bytes code: 2 bytes

    // Data types the packetiser commonly hands us
    localparam logic [5:0] DT_EOTP              = 6'h08;
    localparam logic [5:0] DT_DCS_SHORT_WRITE_0 = 6'h05;
    localparam logic [5:0] DT_DCS_SHORT_WRITE_1 = 6'h15;
    localparam logic [5:0] DT_DCS_LONG_WRITE    = 6'h39;

    // Bytes still to send in the current word, capped at 4 without wrapping
    function automatic logic [2:0] min4(input logic [15:0] v);
        return (v >= 16'd4) ? 3'd4 : v[2:0];
    endfunction

    // One byte through CRC-16 x^16+x^12+x^5+1, reflected (LSB first)
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/dsi_packet_assembler_if.sv
// Descriptor, payload and output streams of the DSI packet assembler.
// slave: the assembler's view; master: the surrounding logic's view.
interface dsi_packet_assembler_if;
    logic        pkt_valid;
    logic        pkt_ready;
    logic        pkt_long;
    logic [7:0]  pkt_di;
    logic [15:0] pkt_wc;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_bytes;
    logic        out_last;

    modport slave (
        input  pkt_valid, pkt_long, pkt_di, pkt_wc,
        output pkt_ready,
        input  pl_valid, pl_data,
        output pl_ready,
        output out_valid, out_data, out_bytes, out_last,
        input  out_ready
    );

    modport master (
        output pkt_valid, pkt_long, pkt_di, pkt_wc,
        input  pkt_ready,
        output pl_valid, pl_data,
        input  pl_ready,
        input  out_valid, out_data, out_bytes, out_last,
        output out_ready
    );
endinterface

// File: rtl/crc_calculator.sv
// Running payload CRC-16 (reflected, init 16'hFFFF), 1..4 bytes per update.
module crc_calculator
    import dsi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clear,
    input  logic        i_en,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_bytes_number,   // valid bytes minus 1, byte0 first
    output logic [15:0] o_crc
);
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    // Fold the valid low-order bytes of the word into the CRC, byte0 first
    always_comb begin
        w_crc_next = r_crc;
        for (int i = 0; i < 4; i++) begin
            if (i_bytes_number >= 2'(i)) begin
                w_crc_next = crc16_byte(w_crc_next, i_data[8*i +: 8]);
            end
        end
    end

    // CRC register: reset/clear to the seed, otherwise advance on each word
    always_ff @(posedge clk) begin
        if (!reset_n || i_clear) begin
            r_crc <= CRC_INIT;
        end else if (i_en) begin
            r_crc <= w_crc_next;
        end
    end

    assign o_crc = r_crc;
endmodule

// File: rtl/ecc_calc.sv
// DSI packet-header ECC over {WC, DI}; the two spare bits are always 0.
module ecc_calc (
    input  logic [23:0] i_data,
    output logic [7:0]  o_ecc
);
    // Each parity bit is the XOR of the header bits selected by its mask
    assign o_ecc = {2'b00,
                    ^(i_data & 24'hEFFC00),
                    ^(i_data & 24'hDF03F0),
                    ^(i_data & 24'hB8E38E),
                    ^(i_data & 24'h749A6D),
                    ^(i_data & 24'hF2555B),
                    ^(i_data & 24'hF12CB7)};
endmodule

// File: rtl/dsi_packet_assembler.sv
// DSI packet assembler: header word, payload words, checksum word (long only).
// Build option: define DSI_ASM_CRC_EN to carry the computed payload CRC in
// the checksum word; otherwise the checksum word carries 16'h0000.
module dsi_packet_assembler
    import dsi_pkg::*;
#(
    parameter logic [15:0] WC_MAX = 16'hFFFF
) (
    input  logic                          clk,
    input  logic                          reset_n,
    dsi_packet_assembler_if.slave         bus,
    output logic                          err_wc
);
    state_t      r_state, w_state_next;
    logic [15:0] r_wc, w_wc_next;
    logic        r_long, w_long_next;
    logic [15:0] r_rem, w_rem_next;
    logic        r_out_valid, w_out_valid_next;
    logic [31:0] r_out_data, w_out_data_next;
    logic [1:0]  r_out_bytes, w_out_bytes_next;
    logic        r_out_last, w_out_last_next;
    logic        r_err_wc, w_err_wc_next;

    logic        w_load;
    logic        w_xfer;
    logic        w_pkt_ready;
    logic        w_pl_ready;
    logic        w_drop;
    logic [7:0]  w_ecc;
    logic [2:0]  w_take;
    logic [1:0]  w_pl_bytes;
    logic [15:0] w_csum;

    assign w_load     = !r_out_valid || bus.out_ready;
    assign w_xfer     = r_out_valid && bus.out_ready;
    assign w_drop     = bus.pkt_long && (bus.pkt_wc > WC_MAX);
    assign w_take     = min4(r_rem);
    assign w_pl_bytes = 2'(w_take - 3'd1);

    // A descriptor may be taken in IDLE, or in the very cycle the final word
    // of the previous packet leaves, which is the cycle the FSM returns to IDLE.
    assign w_pkt_ready = (r_state == IDLE) || (w_xfer && r_out_last);

    ecc_calc u_ecc (
        .i_data ({bus.pkt_wc, bus.pkt_di}),
        .o_ecc  (w_ecc)
    );

`ifdef DSI_ASM_CRC_EN
    logic [15:0] w_crc;
    logic        w_crc_en;
    logic        w_crc_clear;

    assign w_crc_en    = bus.pl_valid && bus.pl_ready;
    assign w_crc_clear = (r_state == CRC) && w_xfer;

    crc_calculator u_crc (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_clear        (w_crc_clear),
        .i_en           (w_crc_en),
        .i_data         (bus.pl_data),
        .i_bytes_number (w_pl_bytes),
        .o_crc          (w_crc)
    );

    assign w_csum = w_crc;
`else
    assign w_csum = CSUM_NONE;
`endif

    // Next-state, output-register and handshake decisions
    always_comb begin
        w_state_next     = r_state;
        w_wc_next        = r_wc;
        w_long_next      = r_long;
        w_rem_next       = r_rem;
        w_out_valid_next = w_load ? 1'b0 : r_out_valid;
        w_out_data_next  = r_out_data;
        w_out_bytes_next = r_out_bytes;
        w_out_last_next  = r_out_last;
        w_err_wc_next    = 1'b0;
        w_pl_ready       = 1'b0;

        case (r_state)
            IDLE: begin
            end
            HDR: begin
                if (w_xfer) begin
                    if (!r_long) begin
                        w_state_next = IDLE;
                    end else if (r_wc == 16'd0) begin
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = {16'h0000, w_csum};
                        w_out_bytes_next = CSUM_BYTES;
                        w_out_last_next  = 1'b1;
                        w_state_next     = CRC;
                    end else begin
                        w_rem_next   = r_wc;
                        w_state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (r_rem != 16'd0) begin
                    w_pl_ready = w_load;
                    if (bus.pl_valid && w_load) begin
                        // Unused upper bytes of a short final word pass through as-is
                        w_out_valid_next = 1'b1;
                        w_out_data_next  = bus.pl_data;
                        w_out_bytes_next = w_pl_bytes;
                        w_out_last_next  = 1'b0;
                        w_rem_next       = r_rem - {13'd0, w_take};
                    end
                end else if (w_load) begin
                    // CRC register already holds the last word's contribution here
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = {16'h0000, w_csum};
                    w_out_bytes_next = CSUM_BYTES;
                    w_out_last_next  = 1'b1;
                    w_state_next     = CRC;
                end
            end
            CRC: begin
                if (w_xfer) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Descriptor accept overrides the packet that is just finishing
        if (w_pkt_ready && bus.pkt_valid) begin
            w_wc_next   = bus.pkt_wc;
            w_long_next = bus.pkt_long;
            if (w_drop) begin
                w_err_wc_next = 1'b1;
                w_state_next  = IDLE;
            end else begin
                w_out_valid_next = 1'b1;
                w_out_data_next  = {w_ecc, bus.pkt_wc, bus.pkt_di};
                w_out_bytes_next = HDR_BYTES;
                w_out_last_next  = !bus.pkt_long;
                w_state_next     = HDR;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_wc        <= 16'd0;
            r_long      <= 1'b0;
            r_rem       <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_bytes <= 2'd0;
            r_out_last  <= 1'b0;
            r_err_wc    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wc        <= w_wc_next;
            r_long      <= w_long_next;
            r_rem       <= w_rem_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_out_bytes <= w_out_bytes_next;
            r_out_last  <= w_out_last_next;
            r_err_wc    <= w_err_wc_next;
        end
    end

    assign bus.pkt_ready = reset_n && w_pkt_ready;
    assign bus.pl_ready  = reset_n && w_pl_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_bytes = r_out_bytes;
    assign bus.out_last  = r_out_last;
    assign err_wc        = r_err_wc;
endmodule

// File: tb/tb_dsi_packet_assembler.sv
// Directed bench for dsi_packet_assembler (WC_MAX = 64).
// Expected checksum words depend on DSI_ASM_CRC_EN.
module tb_dsi_packet_assembler;

    localparam logic [15:0] TB_WC_MAX = 16'd64;
`ifdef DSI_ASM_CRC_EN
    localparam bit CRC_ON = 1'b1;
`else
    localparam bit CRC_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic err_wc;

    dsi_packet_assembler_if bus();

    dsi_packet_assembler #(.WC_MAX(TB_WC_MAX)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .err_wc  (err_wc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pl_words[$];
    logic [31:0] cap_data[$];
    logic [1:0]  cap_bytes[$];
    logic        cap_last[$];
    int pl_ready_cnt, pl_acc_cnt, err_cnt, stall_err, valid_cnt, acc_cyc, first_cyc;
    bit last_seen;

    function automatic logic [31:0] exp_csum(input logic [15:0] crc);
        return {16'h0000, (CRC_ON ? crc : 16'h0000)};
    endfunction

    // Bit-serial reflected CRC-16 reference
    function automatic logic [15:0] crc_ref(input logic [7:0] bytes[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (bytes[k]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb;
                fb = c[0] ^ bytes[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    // Drives one descriptor plus pl_words and records every output transfer
    task automatic run_pkt(input logic lng, input logic [7:0] di, input logic [15:0] wc,
                           input bit rand_ready, input int abort_pl, input int max_cyc);
        bit pkt_done = 1'b0;
        int idx = 0;
        bit prev_stall = 1'b0;
        logic [31:0] pd = '0;
        logic [1:0]  pb = '0;
        logic        plst = 1'b0;
        cap_data.delete(); cap_bytes.delete(); cap_last.delete();
        pl_ready_cnt = 0; pl_acc_cnt = 0; err_cnt = 0; stall_err = 0; valid_cnt = 0;
        acc_cyc = -1; first_cyc = -1; last_seen = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.pkt_long  = lng;
            bus.pkt_di    = di;
            bus.pkt_wc    = wc;
            bus.pkt_valid = !pkt_done;
            bus.pl_valid  = (idx < pl_words.size());
            if (idx < pl_words.size()) bus.pl_data = pl_words[idx];
            else                       bus.pl_data = 32'h0;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (bus.out_valid) begin
                valid_cnt++;
                if (first_cyc < 0) first_cyc = c;
            end
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                               bus.out_bytes !== pb || bus.out_last !== plst))
                stall_err++;
            prev_stall = bus.out_valid && !bus.out_ready;
            pd = bus.out_data; pb = bus.out_bytes; plst = bus.out_last;
            if (bus.out_valid && bus.out_ready) begin
                cap_data.push_back(bus.out_data);
                cap_bytes.push_back(bus.out_bytes);
                cap_last.push_back(bus.out_last);
                $display("xfer data=%h bytes=%0d last=%0d", bus.out_data, bus.out_bytes, bus.out_last);
                if (bus.out_last) last_seen = 1'b1;
            end
            if (bus.pl_ready) pl_ready_cnt++;
            if (err_wc) err_cnt++;
            if (bus.pkt_valid && bus.pkt_ready) begin pkt_done = 1'b1; acc_cyc = c; end
            if (bus.pl_valid && bus.pl_ready) begin idx++; pl_acc_cnt++; end
            @(posedge clk); #1;
            if (last_seen) break;
            if (abort_pl > 0 && pl_acc_cnt >= abort_pl) break;
            if (lng && wc > TB_WC_MAX && pkt_done && c >= acc_cyc + 3) break;
        end
        bus.pkt_valid = 1'b0;
        bus.pl_valid  = 1'b0;
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset();
        bus.pkt_valid = 0; bus.pkt_long = 0; bus.pkt_di = 0; bus.pkt_wc = 0;
        bus.pl_valid = 0; bus.pl_data = 0; bus.out_ready = 1;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        n_checks++; if (bus.pkt_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pkt_ready: got %b expected 0", bus.pkt_ready); end
        n_checks++; if (bus.pl_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pl_ready: got %b expected 0", bus.pl_ready); end
        n_checks++; if (err_wc !== 1'b0) begin n_fail++; $display("FAIL rst_err_wc: got %b expected 0", err_wc); end
        n_checks++; if (bus.out_data !== 32'h0 || bus.out_bytes !== 2'd0 || bus.out_last !== 1'b0) begin
            n_fail++; $display("FAIL rst_out_regs: got data=%h bytes=%0d last=%b expected 0/0/0", bus.out_data, bus.out_bytes, bus.out_last); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.pkt_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_pkt_ready: got %b expected 1", bus.pkt_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_short();
        pl_words.delete();
        run_pkt(1'b0, 8'h05, 16'h0011, 1'b0, 0, 20);
        n_checks++; if (cap_data.size() !== 1) begin n_fail++; $display("FAIL short_count: got %0d expected 1", cap_data.size()); end
        n_checks++; if (cap_data[0] !== 32'h36001105) begin n_fail++; $display("FAIL short_hdr: got %h expected 36001105", cap_data[0]); end
        n_checks++; if (cap_bytes[0] !== 2'd3 || cap_last[0] !== 1'b1) begin n_fail++; $display("FAIL short_flags: got bytes=%0d last=%b expected 3/1", cap_bytes[0], cap_last[0]); end
        n_checks++; if (first_cyc !== acc_cyc + 1) begin n_fail++; $display("FAIL short_latency: got out at %0d accept at %0d expected accept+1", first_cyc, acc_cyc); end
    endtask

    task automatic test_long9();
        logic [31:0] exp_d[5] = '{32'h30000939, 32'h34333231, 32'h38373635, 32'h00000039, exp_csum(16'h6F91)};
        logic [1:0]  exp_b[5] = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
        logic        exp_l[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pl_words = '{32'h34333231, 32'h38373635, 32'h00000039};
        run_pkt(1'b1, 8'h39, 16'd9, 1'b0, 0, 40);
        n_checks++; if (last_seen !== 1'b1 || cap_data.size() !== 5) begin n_fail++; $display("FAIL long9_count: got %0d words last=%b expected 5/1", cap_data.size(), last_seen); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap_data[i] !== exp_d[i] || cap_bytes[i] !== exp_b[i] || cap_last[i] !== exp_l[i]) begin
                n_fail++;
                $display("FAIL long9_word%0d: got %h/%0d/%b expected %h/%0d/%b", i, cap_data[i], cap_bytes[i], cap_last[i], exp_d[i], exp_b[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_long_wc0();
        pl_words = '{32'hDEADBEEF};
        run_pkt(1'b1, 8'h39, 16'd0, 1'b0, 0, 20);
        n_checks++; if (cap_data.size() !== 2) begin n_fail++; $display("FAIL wc0_count: got %0d expected 2", cap_data.size()); end
        n_checks++; if (cap_data[0] !== 32'h0F000039 || cap_last[0] !== 1'b0) begin n_fail++; $display("FAIL wc0_hdr: got %h last=%b expected 0F000039 last=0", cap_data[0], cap_last[0]); end
        n_checks++; if (cap_data[1] !== exp_csum(16'hFFFF) || cap_bytes[1] !== 2'd1 || cap_last[1] !== 1'b1) begin
            n_fail++; $display("FAIL wc0_csum: got %h/%0d/%b expected %h/1/1", cap_data[1], cap_bytes[1], cap_last[1], exp_csum(16'hFFFF)); end
        n_checks++; if (pl_ready_cnt !== 0) begin n_fail++; $display("FAIL wc0_pl_ready: got %0d cycles expected 0", pl_ready_cnt); end
    endtask

    task automatic test_stall_64();
        logic [7:0] bytes[$];
        logic [15:0] crc;
        bytes.delete(); pl_words.delete();
        for (int k = 0; k < 64; k++) bytes.push_back(8'(k * 7 + 3));
        for (int j = 0; j < 16; j++) pl_words.push_back({bytes[4*j+3], bytes[4*j+2], bytes[4*j+1], bytes[4*j]});
        crc = crc_ref(bytes);
        run_pkt(1'b1, 8'h39, 16'd64, 1'b1, 0, 400);
        n_checks++; if (last_seen !== 1'b1 || cap_data.size() !== 18) begin n_fail++; $display("FAIL stall_count: got %0d words last=%b expected 18/1", cap_data.size(), last_seen); end
        n_checks++; if (cap_data[0] !== 32'h25004039) begin n_fail++; $display("FAIL stall_hdr: got %h expected 25004039", cap_data[0]); end
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (cap_data[j+1] !== pl_words[j] || cap_bytes[j+1] !== 2'd3 || cap_last[j+1] !== 1'b0) begin
                n_fail++; $display("FAIL stall_word%0d: got %h/%0d/%b expected %h/3/0", j, cap_data[j+1], cap_bytes[j+1], cap_last[j+1], pl_words[j]);
            end
        end
        n_checks++; if (cap_data[17] !== exp_csum(crc) || cap_last[17] !== 1'b1) begin n_fail++; $display("FAIL stall_csum: got %h last=%b expected %h last=1", cap_data[17], cap_last[17], exp_csum(crc)); end
        n_checks++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d changes while stalled expected 0", stall_err); end
        n_checks++; if (pl_acc_cnt !== 16) begin n_fail++; $display("FAIL stall_pl_accepts: got %0d expected 16", pl_acc_cnt); end
    endtask

    task automatic test_wc_err();
        pl_words = '{32'h11223344};
        run_pkt(1'b1, 8'h39, TB_WC_MAX + 16'd1, 1'b0, 0, 30);
        n_checks++; if (err_cnt !== 1) begin n_fail++; $display("FAIL err_pulse: got %0d cycles expected 1", err_cnt); end
        n_checks++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL err_no_output: got %0d valid cycles expected 0", valid_cnt); end
        n_checks++; if (pl_acc_cnt !== 0) begin n_fail++; $display("FAIL err_no_payload: got %0d accepts expected 0", pl_acc_cnt); end
        pl_words.delete();
        run_pkt(1'b0, 8'h05, 16'h0011, 1'b0, 0, 20);
        n_checks++; if (cap_data.size() !== 1 || cap_data[0] !== 32'h36001105) begin n_fail++; $display("FAIL err_next_pkt: got %0d words first=%h expected 1/36001105", cap_data.size(), cap_data[0]); end
    endtask

    task automatic test_back_to_back();
        int n_acc = 0;
        int acc_c[2] = '{-1, -1};
        logic [31:0] got[$];
        int got_c[$];
        bus.out_ready = 1'b1; bus.pl_valid = 1'b0;
        bus.pkt_valid = 1'b1; bus.pkt_long = 1'b0; bus.pkt_di = 8'h05; bus.pkt_wc = 16'h0011;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data); got_c.push_back(c);
                $display("xfer data=%h bytes=%0d last=%0d", bus.out_data, bus.out_bytes, bus.out_last);
            end
            if (bus.pkt_valid && bus.pkt_ready) begin
                if (n_acc < 2) acc_c[n_acc] = c;
                n_acc++;
            end
            @(posedge clk); #1;
            if (n_acc == 1) begin bus.pkt_di = 8'h15; bus.pkt_wc = 16'h0203; end
            if (n_acc >= 2) bus.pkt_valid = 1'b0;
            if (got.size() >= 2) break;
        end
        bus.pkt_valid = 1'b0;
        n_checks++; if (got.size() !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d expected 2", got.size()); end
        n_checks++; if (got[0] !== 32'h36001105 || got[1] !== 32'h2D020315) begin n_fail++; $display("FAIL b2b_data: got %h %h expected 36001105 2D020315", got[0], got[1]); end
        n_checks++; if (acc_c[1] !== got_c[0]) begin n_fail++; $display("FAIL b2b_accept_cycle: got %0d expected %0d", acc_c[1], got_c[0]); end
        n_checks++; if (got_c[1] !== got_c[0] + 1) begin n_fail++; $display("FAIL b2b_gap: got cycles %0d,%0d expected consecutive", got_c[0], got_c[1]); end
    endtask

    task automatic test_reset_mid();
        pl_words = '{32'h34333231, 32'h38373635, 32'h00000039};
        run_pkt(1'b1, 8'h39, 16'd9, 1'b0, 1, 40);
        n_checks++; if (pl_acc_cnt !== 1) begin n_fail++; $display("FAIL mid_setup: got %0d payload accepts expected 1", pl_acc_cnt); end
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.pkt_ready !== 1'b0 || bus.pl_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got pkt=%b pl=%b expected 0/0", bus.pkt_ready, bus.pl_ready); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.out_valid !== 1'b0 || bus.pkt_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_rst: got valid=%b pkt_ready=%b expected 0/1", bus.out_valid, bus.pkt_ready); end
        @(posedge clk); #1;
        run_pkt(1'b1, 8'h39, 16'd9, 1'b0, 0, 40);
        n_checks++; if (cap_data.size() !== 5) begin n_fail++; $display("FAIL mid_next_count: got %0d expected 5", cap_data.size()); end
        n_checks++; if (cap_data[4] !== exp_csum(16'h6F91)) begin n_fail++; $display("FAIL mid_next_csum: got %h expected %h", cap_data[4], exp_csum(16'h6F91)); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_long9();
        test_long_wc0();
        test_stall_64();
        test_wc_err();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
